irq_ctrl: RTL
=============

Name: irq_ctrl

Overview:
- Interrupt controller that sits directly downstream of the timer blocks. It consumes their IRQ lines, plus external device interrupt lines, and produces the HWInt vector fed to CP0.
- Each source is synchronised, edge- or level-qualified, latched into a pending register and masked.
- It is memory-mapped on the same word-addressed bus as the timers (Addr[31:2], WE, Din, Dout), so the handler can query, acknowledge and inject interrupts.

Parameters:
N_SRC, 6, number of interrupt sources; width of irq_in and HWInt (1..8).
SYNC_STAGES, 2, flip-flop synchroniser depth on every irq_in bit (>=1).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset: 0 clears all state immediately, independent of clk.
Addr  input  30  word address [31:2]; only Addr[4:2] is decoded.
WE  input  1  register write enable, one cycle per write.
Din  input  32  write data.
Dout  output  32  combinational read data for Addr[4:2].
irq_in  input  N_SRC  raw interrupt lines (timer IRQs, external), may be asynchronous.
HWInt  output  N_SRC  pend & mask, to CP0 Cause.IP.
int_req  output  1  OR-reduction of HWInt.

Behaviour:
- Register map, offset = Addr[4:2]. Unused bits read 0 and ignore writes.
  - 0 PEND: read pending[N_SRC-1:0]. Write: each 1 bit clears that pending bit if the source is in edge mode. No effect in level mode.
  - 1 MASK: RW mask[N_SRC-1:0]. 1 = enabled.
  - 2 MODE: RW mode[N_SRC-1:0]. 1 = edge, 0 = level.
  - 3 VEC: read-only. Bit 31 = int_req; bits[2:0] = index of the lowest-numbered set bit of HWInt (index 0 = highest priority). Reads 0 when int_req=0.
  - 4 SWSET: write-only, reads 0. Each 1 bit sets pending for edge-mode sources; ignored for level-mode sources.
  - 5..7: read 0, writes ignored.
- Reset (reset=0, asynchronous): sync chain, edge-history register, pending, mask and mode all cleared. All sources become level mode and masked. HWInt=0, int_req=0, Dout reflects the cleared registers.
- Synchroniser: irq_in[i] passes through SYNC_STAGES flops to give s[i]. A history flop holds s_d[i] = previous s[i].
- Edge mode: a rising edge is s[i] & ~s_d[i].
  - A rising edge sets pending[i] on the next clk edge.
  - Latency: irq_in rising before clk edge k makes pending visible after clk edge k+SYNC_STAGES. With default parameters, HWInt asserts 2 cycles after the first sampling edge, and 3 edges total including the edge-detect registration.
  - Pending stays set until a W1C to PEND. A held-high input does not re-set it after clearing.
- Level mode: pending[i] <= s[i] every cycle. W1C and SWSET have no effect. Pending follows the input with SYNC_STAGES+1 cycles of latency.
- Simultaneous events on the same edge-mode bit:
  - Edge detect and W1C in the same cycle: set wins, pending stays 1.
  - Edge and SWSET in the same cycle: 1.
- Mode change:
  - Writing MODE bit 1->0 makes pending track s[i] from the next cycle.
  - Writing MODE bit 0->1 keeps the current pending value. The history flop is always updated, so no spurious edge is produced.
- Mask does not gate latching. pending is set regardless of mask; unmasking a pending bit asserts HWInt combinationally in the same cycle the MASK write takes effect.
- Register writes take effect on the clk edge where WE=1. A read at the same address in the following cycle returns the new value.

Test Plan:
- Reset: hold reset=0 with irq_in=6'h3F -> PEND, MASK, MODE = 0; HWInt=0; int_req=0. Release reset and wait 4 cycles -> PEND=6'h3F (level mode), HWInt=0 because mask=0.
- Edge latch and ack: MODE=6'h01, MASK=6'h01; pulse irq_in[0] high for 1 cycle.
  - PEND=1 and HWInt=6'h01 three edges after sampling; VEC=32'h8000_0000.
  - Write PEND<=1 -> PEND=0 next cycle, int_req=0.
  - Hold irq_in[0] high afterwards -> no re-trigger.
- Level follow: MODE=0, MASK=6'h04; raise irq_in[2] -> HWInt=6'h04 after SYNC_STAGES+1 edges. Write PEND<=4 -> still 4. Drop irq_in[2] -> 0 after 3 edges.
- Priority: MASK=6'h3F, MODE=6'h3F; SWSET<=6'h28 -> HWInt=6'h28, VEC=32'h8000_0003. W1C 6'h08 -> VEC=32'h8000_0005.
- Set/clear collision: edge mode on bit 1. Time the W1C PEND<=2 on the same clk edge as the detected rising edge -> PEND bit1 remains 1.
- Async reset mid-operation: with pending=6'h3F, drop reset between clk edges -> HWInt=0 immediately, before the next clk edge. Reads at offsets 5..7 -> 0.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises raw IRQ lines, qualifies them as edge or level,
// latches them into a pending register and masks them into the HWInt vector for CP0.
module irq_ctrl #(
  parameter int N_SRC       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  input  logic [N_SRC-1:0]  irq_in,
  output logic [N_SRC-1:0]  HWInt,
  output logic              int_req
);

  localparam logic [2:0] OFF_PEND  = 3'd0;
  localparam logic [2:0] OFF_MASK  = 3'd1;
  localparam logic [2:0] OFF_MODE  = 3'd2;
  localparam logic [2:0] OFF_VEC   = 3'd3;
  localparam logic [2:0] OFF_SWSET = 3'd4;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
  logic [N_SRC-1:0] hist_q, hist_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;

  logic [2:0]       offset;
  logic [N_SRC-1:0] s_cur;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] swset;
  logic [2:0]       vec_idx;

  // Only Addr[4:2] and Din[N_SRC-1:0] are decoded.
  logic unused_bits;
  assign unused_bits = ^{Addr[31:5], Din};

  assign offset = Addr[4:2];
  assign s_cur  = sync_q[SYNC_STAGES-1];
  assign rise   = s_cur & ~hist_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    w1c    = '0;
    swset  = '0;
    mask_d = mask_q;
    mode_d = mode_q;
    hist_d = s_cur;
    if (WE) begin
      case (offset)
        OFF_PEND:  w1c    = Din[N_SRC-1:0];
        OFF_MASK:  mask_d = Din[N_SRC-1:0];
        OFF_MODE:  mode_d = Din[N_SRC-1:0];
        OFF_SWSET: swset  = Din[N_SRC-1:0];
        default:   ;
      endcase
    end
    // Edge bits: set (detect or SWSET) beats a same-cycle W1C. Level bits mirror s.
    pend_d = (mode_q & ((pend_q & ~w1c) | rise | swset)) | (~mode_q & s_cur);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      mode_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
    end
  end

  assign HWInt   = pend_q & mask_q;
  assign int_req = |HWInt;

  // Scan downwards so the lowest-numbered active source wins.
  always_comb begin
    vec_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (HWInt[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    Dout = '0;
    case (offset)
      OFF_PEND: Dout[N_SRC-1:0] = pend_q;
      OFF_MASK: Dout[N_SRC-1:0] = mask_q;
      OFF_MODE: Dout[N_SRC-1:0] = mode_q;
      OFF_VEC: begin
        Dout[31]  = int_req;
        Dout[2:0] = vec_idx;
      end
      default: Dout = '0;
    endcase
  end

endmodule
